vx_lsu_local_mem: RTL and testbench

Lane-private scratchpad that responds to the LSU memory bus protocol: it accepts multi-lane load/store requests from an `lsu_mem` initiator and returns tagged, in-order responses. It sits on the downstream side of the LSU/SFU memory arbiter, as a local-memory target, with one byte-enabled SRAM bank per lane. A credit counter and a response queue absorb back-pressure, so no accepted request is ever dropped.

---
 rtl/VX_gpu_pkg.sv | 27 ++
 rtl/VX_fifo_queue.sv | 65 ++++++
 rtl/vx_lsu_local_mem_bank.sv | 43 ++++
 rtl/vx_lsu_local_mem.sv | 128 ++++++++++++
 tb/tb_vx_lsu_local_mem.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared types and constants for the LSU local-memory target.
package VX_gpu_pkg;

    localparam int unsigned LMEM_RSP_DEPTH_MIN = 2;

    localparam int unsigned LMEM_NUM_LANES  = 4;
    localparam int unsigned LMEM_DATA_SIZE  = 4;
    localparam int unsigned LMEM_ADDR_WIDTH = 8;
    localparam int unsigned LMEM_TAG_WIDTH  = 8;
    localparam int unsigned LMEM_RSP_DEPTH  = 4;

    typedef struct packed {
        logic                                        rw;
        logic [LMEM_NUM_LANES-1:0]                   mask;
        logic [LMEM_NUM_LANES*LMEM_DATA_SIZE-1:0]    byteen;
        logic [LMEM_NUM_LANES*LMEM_ADDR_WIDTH-1:0]   addr;
        logic [LMEM_NUM_LANES*LMEM_DATA_SIZE*8-1:0]  data;
        logic [LMEM_TAG_WIDTH-1:0]                   tag;
    } lmem_req_t;

    typedef struct packed {
        logic [LMEM_NUM_LANES-1:0]                   mask;
        logic [LMEM_NUM_LANES*LMEM_DATA_SIZE*8-1:0]  data;
        logic [LMEM_TAG_WIDTH-1:0]                   tag;
    } lmem_rsp_t;

endpackage

// File: rtl/VX_fifo_queue.sv
// Generic synchronous FIFO; the head entry is visible combinationally from storage.
module VX_fifo_queue #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [DATAW-1:0] data_i,
    output logic [DATAW-1:0] data_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vx_lsu_local_mem_bank.sv
// One lane of local memory: byte-enabled write, registered read.
module vx_lsu_local_mem_bank import VX_gpu_pkg::*; #(
    parameter int unsigned DATA_SIZE  = LMEM_DATA_SIZE,
    parameter int unsigned ADDR_WIDTH = LMEM_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en_i,
    input  logic                   wr_en_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [DATA_SIZE-1:0]   byteen_i,
    input  logic [DATA_SIZE*8-1:0] wdata_i,
    output logic [DATA_SIZE*8-1:0] rdata_o
);

    localparam int unsigned WORD_W = DATA_SIZE * 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    assign rdata_o = rdata_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < int'(DATA_SIZE); b++) begin
                if (byteen_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/vx_lsu_local_mem.sv
// Multi-lane local scratchpad on the LSU memory bus with credit-based in-order responses.
// Define LMEM_WRITE_RSP_EN to make writes return a (data=0) response as well.
module vx_lsu_local_mem import VX_gpu_pkg::*; #(
    parameter int unsigned NUM_LANES  = LMEM_NUM_LANES,
    parameter int unsigned DATA_SIZE  = LMEM_DATA_SIZE,
    parameter int unsigned ADDR_WIDTH = LMEM_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH  = LMEM_TAG_WIDTH,
    parameter int unsigned RSP_DEPTH  = LMEM_RSP_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    input  logic                            req_rw,
    input  logic [NUM_LANES-1:0]            req_mask,
    input  logic [NUM_LANES*DATA_SIZE-1:0]  req_byteen,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_LANES*DATA_SIZE*8-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    output logic                            req_ready,
    output logic                            rsp_valid,
    output logic [NUM_LANES-1:0]            rsp_mask,
    output logic [NUM_LANES*DATA_SIZE*8-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    input  logic                            rsp_ready
);

    localparam int unsigned WORD_W = DATA_SIZE * 8;
    localparam int unsigned CW     = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [NUM_LANES-1:0]        mask;
        logic [NUM_LANES*WORD_W-1:0] data;
        logic [TAG_WIDTH-1:0]        tag;
    } rsp_t;

    if (RSP_DEPTH < LMEM_RSP_DEPTH_MIN) begin : g_depth_check
        $error("vx_lsu_local_mem: RSP_DEPTH below minimum");
    end

    logic                 fire, rsp_fire, deq;
    logic [CW-1:0]        credits_q, credits_d;
    logic                 s1_valid_q;
    logic                 s1_rw_q;
    logic [NUM_LANES-1:0] s1_mask_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    logic [WORD_W-1:0]    bank_rdata [NUM_LANES];
    logic [NUM_LANES*WORD_W-1:0] s1_data;
    rsp_t                 push_rsp, head_rsp;
    logic                 fifo_empty;

    assign req_ready = (credits_q != CW'(RSP_DEPTH));
    assign fire      = req_valid && req_ready;
`ifdef LMEM_WRITE_RSP_EN
    assign rsp_fire  = fire;
`else
    assign rsp_fire  = fire && !req_rw;
`endif
    assign deq       = rsp_valid && rsp_ready;

    // Credits cover every response between acceptance and dequeue (s1 plus FIFO).
    always_comb begin
        credits_d = credits_q;
        case ({rsp_fire, deq})
            2'b10:   credits_d = credits_q + CW'(1);
            2'b01:   credits_d = credits_q - CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_rw_q    <= 1'b0;
            s1_mask_q  <= '0;
            s1_tag_q   <= '0;
        end else begin
            credits_q  <= credits_d;
            s1_valid_q <= rsp_fire;
            if (rsp_fire) begin
                s1_rw_q   <= req_rw;
                s1_mask_q <= req_mask;
                s1_tag_q  <= req_tag;
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
        vx_lsu_local_mem_bank #(
            .DATA_SIZE  (DATA_SIZE),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .rd_en_i  (fire && !req_rw && req_mask[i]),
            .wr_en_i  (fire && req_rw && req_mask[i]),
            .addr_i   (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .byteen_i (req_byteen[i*DATA_SIZE +: DATA_SIZE]),
            .wdata_i  (req_data[i*WORD_W +: WORD_W]),
            .rdata_o  (bank_rdata[i])
        );
        // Inactive lanes and write responses return zero data.
        assign s1_data[i*WORD_W +: WORD_W] = (s1_mask_q[i] && !s1_rw_q) ? bank_rdata[i] : '0;
    end

    assign push_rsp.mask = s1_mask_q;
    assign push_rsp.data = s1_data;
    assign push_rsp.tag  = s1_tag_q;

    VX_fifo_queue #(
        .DATAW (int'($bits(rsp_t))),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (s1_valid_q),
        .pop_i   (deq),
        .data_i  (push_rsp),
        .data_o  (head_rsp),
        .empty_o (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_mask  = rsp_valid ? head_rsp.mask : '0;
    assign rsp_data  = rsp_valid ? head_rsp.data : '0;
    assign rsp_tag   = rsp_valid ? head_rsp.tag  : '0;

endmodule

// File: tb/tb_vx_lsu_local_mem.sv
// Scoreboard bench for vx_lsu_local_mem: directed requests push expected responses,
// a negedge monitor pops and compares every dequeued response.
module tb_vx_lsu_local_mem;

    typedef struct {
        logic [7:0]   tag;
        logic [3:0]   mask;
        logic [127:0] data;
    } exp_t;

`ifdef LMEM_WRITE_RSP_EN
    localparam bit WRSP = 1'b1;
`else
    localparam bit WRSP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_rw, req_ready;
    logic [3:0]   req_mask;
    logic [15:0]  req_byteen;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic [7:0]   req_tag;
    logic         rsp_valid, rsp_ready;
    logic [3:0]   rsp_mask;
    logic [127:0] rsp_data;
    logic [7:0]   rsp_tag;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pop_count = 0;
    int   last_pop_cyc = 0;
    int   fire_cyc = 0;

    vx_lsu_local_mem dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_mask   (req_mask),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_mask   (rsp_mask),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each dequeued response against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got tag=%h mask=%h data=%h, wanted no response",
                         rsp_tag, rsp_mask, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_tag !== e.tag || rsp_mask !== e.mask || rsp_data !== e.data) begin
                    n_err++;
                    $display("FAIL rsp_tag%h: got tag=%h mask=%h data=%h, wanted tag=%h mask=%h data=%h",
                             e.tag, rsp_tag, rsp_mask, rsp_data, e.tag, e.mask, e.data);
                end
            end
            pop_count++;
            last_pop_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, got, want);
        end
    endtask

    // Drive one request until it fires; expected response is queued at acceptance.
    task automatic issue(input logic rw, input logic [3:0] mask, input logic [15:0] be,
                         input logic [31:0] addr, input logic [127:0] data, input logic [7:0] tag,
                         input logic [127:0] exp_data, output int attempts);
        bit fired = 0;
        attempts = 0;
        req_valid = 1'b1; req_rw = rw; req_mask = mask; req_byteen = be;
        req_addr = addr; req_data = data; req_tag = tag;
        for (int k = 0; k < 64 && !fired; k++) begin
            @(negedge clk);
            attempts++;
            if (req_ready) begin
                fired = 1;
                fire_cyc = cyc;
                if (!rw || WRSP) begin
                    exp_t e;
                    e.tag = tag; e.mask = mask; e.data = rw ? 128'h0 : exp_data;
                    sb.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!fired) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout tag=%h: got no acceptance in 64 cycles, wanted acceptance", tag);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        check("drain_left", 128'(sb.size()), 128'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] MULTI = 128'h33333333_22222222_11111111_01010101;

    initial begin
        int att, tot, base;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_mask = '0; req_byteen = '0;
        req_addr = '0; req_data = '0; req_tag = '0; rsp_ready = 1'b0;
        #3;
        check("rst_req_ready", 128'(req_ready), 128'h1);
        check("rst_rsp_valid", 128'(rsp_valid), 128'h0);
        check("rst_rsp_tag",   128'(rsp_tag),   128'h0);
        check("rst_rsp_mask",  128'(rsp_mask),  128'h0);
        check("rst_rsp_data",  rsp_data,        128'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // Write then read, with latency check on the read.
        issue(1'b1, 4'h1, 16'h000F, 32'h0000_0010, 128'hDEADBEEF, 8'h01, 128'h0, att);
        drain();
        issue(1'b0, 4'h1, 16'h0000, 32'h0000_0010, 128'h0, 8'h5A, 128'hDEADBEEF, att);
        @(negedge clk);
        check("lat_early", 128'(rsp_valid), 128'h0);
        @(negedge clk);
        check("lat_valid", 128'(rsp_valid), 128'h1);
        drain();

        // Byte enables: back-to-back writes then read.
        issue(1'b1, 4'h2, 16'h00F0, 32'h0000_2000, {64'h0, 32'hFFFFFFFF, 32'h0}, 8'h02, 128'h0, att);
        issue(1'b1, 4'h2, 16'h0050, 32'h0000_2000, 128'h0, 8'h03, 128'h0, att);
        issue(1'b0, 4'h2, 16'h0000, 32'h0000_2000, 128'h0, 8'h04, {64'h0, 32'hFF00FF00, 32'h0}, att);
        drain();

        // All lanes written, read with lane 2 masked off.
        issue(1'b1, 4'hF, 16'hFFFF, 32'h4342_4140, MULTI, 8'h05, 128'h0, att);
        issue(1'b0, 4'hB, 16'h0000, 32'h4342_4140, 128'h0, 8'h06,
              128'h33333333_00000000_11111111_01010101, att);
        drain();

        // Back-pressure: four accepts, then stall until the first dequeue.
        rsp_ready = 1'b0;
        tot = 0;
        for (int t = 0; t < 4; t++) begin
            issue(1'b0, 4'hF, 16'h0, 32'h4342_4140, 128'h0, 8'(t), MULTI, att);
            tot += att;
        end
        check("bp_accept_cycles", 128'(tot), 128'h4);
        req_valid = 1'b1; req_rw = 1'b0; req_tag = 8'h04;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_full_ready", 128'(req_ready), 128'h0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_deq", 128'(req_ready), 128'h0);
        @(negedge clk);
        check("bp_ready_after_deq", 128'(req_ready), 128'h1);
        drain();

        // Streaming: 32 reads back to back with no stalls or response bubbles.
        base = pop_count;
        tot = 0;
        for (int t = 0; t < 32; t++) begin
            int fc;
            issue(1'b0, 4'hF, 16'h0, 32'h4342_4140, 128'h0, 8'(t), MULTI, att);
            if (t == 0) fc = fire_cyc;
            tot += att;
            if (t == 31) begin
                drain();
                check("stream_pops", 128'(pop_count - base), 128'd32);
                check("stream_span", 128'(last_pop_cyc - fc), 128'd33);
            end
        end
        check("stream_accept_cycles", 128'(tot), 128'd32);

        // Write / read / write interleave.
        base = pop_count;
        issue(1'b1, 4'h8, 16'hF000, 32'h3000_0000, {32'h11223344, 96'h0}, 8'h20, 128'h0, att);
        issue(1'b0, 4'h8, 16'h0000, 32'h3000_0000, 128'h0, 8'h21, {32'h11223344, 96'h0}, att);
        issue(1'b1, 4'h8, 16'hF000, 32'h3000_0000, {32'h55667788, 96'h0}, 8'h22, 128'h0, att);
        drain();
        check("wrsp_count", 128'(pop_count - base), WRSP ? 128'd3 : 128'd1);

        // Reset with three responses queued.
        rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++)
            issue(1'b0, 4'h1, 16'h0, 32'h0000_0010, 128'h0, 8'h40 + 8'(t), 128'hDEADBEEF, att);
        repeat (2) @(negedge clk);
        check("pre_rst_valid", 128'(rsp_valid), 128'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(rsp_valid), 128'h0);
        check("mid_rst_ready", 128'(req_ready), 128'h1);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 4'h3, 16'h0, 32'h0000_2010, 128'h0, 8'h50, {64'h0, 32'hFF00FF00, 32'hDEADBEEF}, att);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
